// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and write-back source encoding for the register file write-back slice
package regfile_pkg;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 2 ** AW;
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;
endpackage

// File: rtl/regfile_wb_arb.sv
// rr_arb2: two-requester round-robin arbiter
//  clk, reset : clock and synchronous active-high reset
//  req[1:0]   : requests, bit index is src_e (ALU=0, MEM=1)
//  gnt[1:0]   : combinational one-hot grant, zero while reset is high
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    // ptr holds the last granted source; on a tie the other one wins
    src_e ptr;
    always_comb gnt = reset ? 2'b00 : (req == 2'b11) ? ((ptr == SRC_MEM) ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= SRC_MEM;
        else if (|gnt)
            ptr <= gnt[1] ? SRC_MEM : SRC_ALU;
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back arbiter and hazard scoreboard for the 32x32 register file
//  iss_*      : issue request (rs, rt, rd) and combinational stall
//  alu_*      : ALU write-back valid/ready/addr/data
//  mem_*      : load write-back valid/ready/addr/data
//  rf_we/a3/wd: registered write port to reg_file (WE3/A3/WD3)
//  busy       : registered scoreboard, bit r = write to r pending
//  wb_orphan  : registered pulse for a granted write to a non-busy nonzero register
module regfile_wb_ctrl #(
    parameter int AW = regfile_pkg::AW,
    parameter int DW = regfile_pkg::DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rs,
    input  logic [AW-1:0]     iss_rt,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_stall,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW-1:0]     alu_addr,
    input  logic [DW-1:0]     alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_data,
    output logic              rf_we,
    output logic [AW-1:0]     rf_a3,
    output logic [DW-1:0]     rf_wd,
    output logic [2**AW-1:0]  busy,
    output logic              wb_orphan
);
    localparam int NR = 2 ** AW;
    logic [1:0]    gnt;
    logic          grant;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;
    logic          accept;
    logic [NR-1:0] set_v;
    logic [NR-1:0] clr_v;
    logic [NR-1:0] busy_nx;
    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({mem_valid, alu_valid}),
        .gnt   (gnt)
    );
    always_comb begin
        alu_ready = gnt[0];
        mem_ready = gnt[1];
        grant     = |gnt;
        g_addr    = gnt[1] ? mem_addr : alu_addr;
        g_data    = gnt[1] ? mem_data : alu_data;
        iss_stall = reset | (iss_valid & (busy[iss_rs] | busy[iss_rt] | busy[iss_rd]));
        accept    = iss_valid & ~iss_stall;
        set_v     = (accept && iss_rd != '0) ? (NR'(1) << iss_rd) : '0;
        clr_v     = rf_we ? (NR'(1) << rf_a3) : '0;
        // set is applied after clear so a same-edge reissue keeps the register busy
        busy_nx   = ((busy & ~clr_v) | set_v) & ~NR'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we     <= 1'b0;
            rf_a3     <= '0;
            rf_wd     <= '0;
            busy      <= '0;
            wb_orphan <= 1'b0;
        end else begin
            rf_we     <= grant && g_addr != '0;
            wb_orphan <= grant && g_addr != '0 && !busy[g_addr];
            busy      <= busy_nx;
            if (grant) begin
                rf_a3 <= g_addr;
                rf_wd <= g_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed self-checking bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid;
    logic [4:0]  iss_rs, iss_rt, iss_rd;
    logic        iss_stall;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] busy;
    logic        wb_orphan;
    logic [31:0] rf [32];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    regfile_wb_ctrl dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd), .iss_stall(iss_stall),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .busy(busy), .wb_orphan(wb_orphan)
    );
    initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    always @(posedge clk) if (rf_we) rf[rf_a3] <= rf_wd;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_rd = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
    endtask
    task automatic test_reset();
        idle();
        reset = 1; alu_valid = 1; mem_valid = 1; alu_addr = 1; mem_addr = 2;
        iss_valid = 1; iss_rd = 4;
        tick();
        tick();
        checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 00", alu_ready, mem_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", iss_stall); end
        checks++; if (wb_orphan !== 1'b0 || rf_a3 !== 5'd0 || rf_wd !== 32'h0) begin errors++; $display("FAIL reset_regs got %b %0d %h want 0 0 0", wb_orphan, rf_a3, rf_wd); end
        iss_valid = 0;
        reset = 0;
        #1;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL first_tie got alu=%b mem=%b want alu=1 mem=0", alu_ready, mem_ready); end
        idle();
        tick();
    endtask
    task automatic test_alu_only();
        alu_valid = 1; alu_addr = 5; alu_data = 32'h00001234;
        #1;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL alu_grant got alu=%b mem=%b want 1 0", alu_ready, mem_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_a3 !== 5'd5 || rf_wd !== 32'h00001234) begin errors++; $display("FAIL alu_write got we=%b a3=%0d wd=%h want 1 5 00001234", rf_we, rf_a3, rf_wd); end
        checks++; if (wb_orphan !== 1'b1) begin errors++; $display("FAIL alu_orphan got %b want 1", wb_orphan); end
        tick();
        checks++; if (rf_we !== 1'b0 || rf_a3 !== 5'd5) begin errors++; $display("FAIL alu_hold got we=%b a3=%0d want 0 5", rf_we, rf_a3); end
        checks++; if (rf[5] !== 32'h00001234) begin errors++; $display("FAIL alu_rd1 got %h want 00001234", rf[5]); end
    endtask
    task automatic test_round_robin();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_addr = 5'(10 + i); alu_data = 32'hA000 + i;
            mem_valid = 1; mem_addr = 5'(20 + i); mem_data = 32'hB000 + i;
            #1;
            checks++; if (alu_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin errors++; $display("FAIL rr_grant%0d got alu=%b mem=%b want alu=%b", i, alu_ready, mem_ready, (i % 2 == 0)); end
            tick();
            checks++; if (rf_we !== 1'b1 || rf_a3 !== ((i % 2 == 0) ? 5'(10 + i) : 5'(20 + i))) begin errors++; $display("FAIL rr_write%0d got we=%b a3=%0d", i, rf_we, rf_a3); end
            checks++; if (rf_wd !== ((i % 2 == 0) ? 32'hA000 + i : 32'hB000 + i)) begin errors++; $display("FAIL rr_data%0d got %h", i, rf_wd); end
        end
        idle();
        tick();
    endtask
    task automatic test_stall();
        iss_valid = 1; iss_rs = 1; iss_rt = 2; iss_rd = 8;
        #1;
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL stall_first got %b want 0", iss_stall); end
        tick();
        checks++; if (busy !== 32'h0000_0100) begin errors++; $display("FAIL busy8_set got %h want 00000100", busy); end
        iss_rs = 8; iss_rt = 0; iss_rd = 0;
        #1;
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %b want 1", iss_stall); end
        tick();
        mem_valid = 1; mem_addr = 8; mem_data = 32'h0000CAFE;
        #1;
        checks++; if (mem_ready !== 1'b1 || iss_stall !== 1'b1) begin errors++; $display("FAIL stall_t got ready=%b stall=%b want 1 1", mem_ready, iss_stall); end
        tick();
        mem_valid = 0;
        checks++; if (iss_stall !== 1'b1 || rf_we !== 1'b1 || rf_a3 !== 5'd8 || busy[8] !== 1'b1) begin errors++; $display("FAIL stall_t1 got stall=%b we=%b a3=%0d busy8=%b want 1 1 8 1", iss_stall, rf_we, rf_a3, busy[8]); end
        checks++; if (wb_orphan !== 1'b0) begin errors++; $display("FAIL stall_orphan got %b want 0", wb_orphan); end
        tick();
        checks++; if (iss_stall !== 1'b0 || busy[8] !== 1'b0) begin errors++; $display("FAIL stall_t2 got stall=%b busy8=%b want 0 0", iss_stall, busy[8]); end
        checks++; if (rf[8] !== 32'h0000CAFE) begin errors++; $display("FAIL rf8 got %h want 0000cafe", rf[8]); end
        iss_valid = 0;
        tick();
    endtask
    task automatic test_zero();
        alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFFFFFF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rf_we !== 1'b0 || wb_orphan !== 1'b0) begin errors++; $display("FAIL zero_we got we=%b orphan=%b want 0 0", rf_we, wb_orphan); end
        iss_valid = 1; iss_rd = 0;
        tick();
        iss_valid = 0;
        checks++; if (rf[0] !== 32'h0 || busy[0] !== 1'b0) begin errors++; $display("FAIL zero_reg got r0=%h busy0=%b want 0 0", rf[0], busy[0]); end
    endtask
    task automatic test_same_edge();
        alu_valid = 1; alu_addr = 3; alu_data = 32'h33;
        tick();
        alu_valid = 0;
        iss_valid = 1; iss_rs = 0; iss_rt = 0; iss_rd = 3;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_a3 !== 5'd3 || iss_stall !== 1'b0) begin errors++; $display("FAIL same_pre got we=%b a3=%0d stall=%b want 1 3 0", rf_we, rf_a3, iss_stall); end
        tick();
        iss_valid = 0;
        checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL same_edge_busy got %b want 1", busy[3]); end
        mem_valid = 1; mem_addr = 9; mem_data = 32'h99;
        tick();
        mem_valid = 0;
        checks++; if (wb_orphan !== 1'b1) begin errors++; $display("FAIL orphan9 got %b want 1", wb_orphan); end
        tick();
        checks++; if (wb_orphan !== 1'b0 || busy !== 32'h0000_0008) begin errors++; $display("FAIL orphan_end got orphan=%b busy=%h want 0 00000008", wb_orphan, busy); end
    endtask
    initial begin
        test_reset();
        test_alu_only();
        test_round_robin();
        test_stall();
        test_zero();
        test_same_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
